// File: rtl/aqp_ebus_arbiter_if.sv
// ---------------------------------------------------------------------------
// aqp_ebus_arbiter_if
// Bundles the per-master request/strobe inputs, the grant vector and the
// muxed external-bus outputs of the ebus arbiter.
//   slave  : arbiter side (consumes requests and strobes, drives grants and bus)
//   master : requester side (drives requests and strobes, observes grants and bus)
// Signals:
//   clken              bus-phase enable; new grants only issue while high
//   m_req / m_gnt      per-master request / registered one-hot grant
//   m_a, m_wrdata      packed per-master address / write data
//   m_wrdata_en        per-master write-data drive enable
//   m_rd_n .. m_iorq_n per-master control strobes
//   bus_*              muxed bus outputs and output enables
//   owner, owner_valid current/last owner index and grant-active flag
//   hold_timeout(_clr) sticky hold watchdog flag and its clear
// ---------------------------------------------------------------------------
interface aqp_ebus_arbiter_if #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8
);
    localparam int OW = $clog2(NUM_MASTERS);

    logic                          clken;
    logic [NUM_MASTERS-1:0]        m_req;
    logic [NUM_MASTERS-1:0]        m_gnt;
    logic [NUM_MASTERS*ADDR_W-1:0] m_a;
    logic [NUM_MASTERS*DATA_W-1:0] m_wrdata;
    logic [NUM_MASTERS-1:0]        m_wrdata_en;
    logic [NUM_MASTERS-1:0]        m_rd_n;
    logic [NUM_MASTERS-1:0]        m_wr_n;
    logic [NUM_MASTERS-1:0]        m_mreq_n;
    logic [NUM_MASTERS-1:0]        m_iorq_n;
    logic [ADDR_W-1:0]             bus_a;
    logic                          bus_rd_n;
    logic                          bus_wr_n;
    logic                          bus_mreq_n;
    logic                          bus_iorq_n;
    logic                          bus_ctrl_oe;
    logic [DATA_W-1:0]             bus_d_out;
    logic                          bus_d_oe;
    logic [OW-1:0]                 owner;
    logic                          owner_valid;
    logic                          hold_timeout;
    logic                          hold_timeout_clr;

    modport slave (
        input  clken, m_req, m_a, m_wrdata, m_wrdata_en,
               m_rd_n, m_wr_n, m_mreq_n, m_iorq_n, hold_timeout_clr,
        output m_gnt, bus_a, bus_rd_n, bus_wr_n, bus_mreq_n, bus_iorq_n,
               bus_ctrl_oe, bus_d_out, bus_d_oe, owner, owner_valid, hold_timeout
    );

    modport master (
        output clken, m_req, m_a, m_wrdata, m_wrdata_en,
               m_rd_n, m_wr_n, m_mreq_n, m_iorq_n, hold_timeout_clr,
        input  m_gnt, bus_a, bus_rd_n, bus_wr_n, bus_mreq_n, bus_iorq_n,
               bus_ctrl_oe, bus_d_out, bus_d_oe, owner, owner_valid, hold_timeout
    );
endinterface

// File: rtl/aqp_ebus_arbiter.sv
// ---------------------------------------------------------------------------
// aqp_ebus_arbiter
// N-master arbiter for the Z80-style external bus. Each master raises m_req;
// a winner is chosen on a clken-qualified edge (fixed priority or round
// robin), holds the bus until it drops its request, and the bus is then left
// undriven for TURNAROUND clocks before the next grant can be evaluated.
// A watchdog flags owners that keep the bus for MAX_HOLD clken ticks while
// someone else is waiting; it never revokes the grant.
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   ebus     arbiter side of aqp_ebus_arbiter_if (requests in, grants/bus out)
// ---------------------------------------------------------------------------
module aqp_ebus_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int ROUND_ROBIN = 0,
    parameter int TURNAROUND  = 2,
    parameter int MAX_HOLD    = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    aqp_ebus_arbiter_if.slave ebus
);
    localparam int OW     = $clog2(NUM_MASTERS);
    localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_OWNED, ST_TURN} state_t;
    typedef logic [OW-1:0] idx_t;

    localparam logic [NUM_MASTERS-1:0] GNT_LSB   = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
    localparam logic [3:0]             TURN_LOAD = 4'(TURNAROUND);
    localparam logic [HOLD_W-1:0]      HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam idx_t                   PTR_RST   = idx_t'(NUM_MASTERS - 1);

    state_t                 r_state;
    logic [NUM_MASTERS-1:0] r_gnt;
    idx_t                   r_owner;
    logic                   r_owner_valid;
    idx_t                   r_rr_ptr;
    logic [3:0]             r_turn_cnt;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic                   r_hold_timeout;

    state_t                 w_state_nxt;
    logic [NUM_MASTERS-1:0] w_gnt_nxt;
    idx_t                   w_owner_nxt;
    logic                   w_valid_nxt;
    idx_t                   w_ptr_nxt;
    logic [3:0]             w_turn_nxt;
    idx_t                   w_winner;
    logic [NUM_MASTERS-1:0] w_others;
    logic [HOLD_W-1:0]      w_hold_inc;
    logic [HOLD_W-1:0]      w_hold_nxt;
    logic                   w_hold_set;

    // Search starts at index 0 for fixed priority, or just after the last
    // owner for round robin, so the previous owner is tried last.
    function automatic idx_t f_pick(input logic [NUM_MASTERS-1:0] req, input idx_t last);
        idx_t win;
        logic found;
        int   idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (ROUND_ROBIN != 0) idx = (int'(last) + 1 + k) % NUM_MASTERS;
            else                  idx = k;
            if (!found && req[idx_t'(idx)]) begin
                found = 1'b1;
                win   = idx_t'(idx);
            end
        end
        return win;
    endfunction

    assign w_winner = f_pick(ebus.m_req, r_rr_ptr);

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_valid_nxt = r_owner_valid;
        w_ptr_nxt   = r_rr_ptr;
        w_turn_nxt  = r_turn_cnt;
        case (r_state)
            ST_IDLE: begin
                if (ebus.clken && (|ebus.m_req)) begin
                    w_state_nxt = ST_OWNED;
                    w_gnt_nxt   = GNT_LSB << w_winner;
                    w_owner_nxt = w_winner;
                    w_valid_nxt = 1'b1;
                    w_ptr_nxt   = w_winner;
                end
            end
            ST_OWNED: begin
                // Release is immediate (no clken wait) and there is no pre-emption.
                if (!ebus.m_req[r_owner]) begin
                    w_state_nxt = ST_TURN;
                    w_gnt_nxt   = '0;
                    w_valid_nxt = 1'b0;
                    w_turn_nxt  = TURN_LOAD;
                end
            end
            ST_TURN: begin
                // TURN lasts exactly TURNAROUND clocks; the counter is 0 in IDLE.
                if (r_turn_cnt <= 4'd1) begin
                    w_state_nxt = ST_IDLE;
                    w_turn_nxt  = '0;
                end else begin
                    w_turn_nxt  = r_turn_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Watchdog: counts clken ticks while the owner keeps the bus and some
    // other master waits. It saturates at MAX_HOLD so the flag is raised once
    // per waiting episode and a clear sticks until the next episode.
    assign w_others   = ebus.m_req & ~r_gnt;
    assign w_hold_inc = r_hold_cnt + HOLD_W'(1);

    always_comb begin
        w_hold_nxt = '0;
        w_hold_set = 1'b0;
        if ((MAX_HOLD > 0) && (r_state == ST_OWNED) && ebus.m_req[r_owner] && (|w_others)) begin
            w_hold_nxt = r_hold_cnt;
            if (ebus.clken && (r_hold_cnt != HOLD_MAX)) begin
                w_hold_nxt = w_hold_inc;
                w_hold_set = (w_hold_inc == HOLD_MAX);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_gnt          <= '0;
            r_owner        <= '0;
            r_owner_valid  <= 1'b0;
            r_rr_ptr       <= PTR_RST;
            r_turn_cnt     <= '0;
            r_hold_cnt     <= '0;
            r_hold_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_gnt         <= w_gnt_nxt;
            r_owner       <= w_owner_nxt;
            r_owner_valid <= w_valid_nxt;
            r_rr_ptr      <= w_ptr_nxt;
            r_turn_cnt    <= w_turn_nxt;
            r_hold_cnt    <= w_hold_nxt;
            // A new timeout takes precedence over a simultaneous clear.
            if (w_hold_set) begin
                r_hold_timeout <= 1'b1;
            end else if (ebus.hold_timeout_clr) begin
                r_hold_timeout <= 1'b0;
            end
        end
    end

    // Bus mux is combinational from the registered owner so master strobes
    // reach the bus with no added latency.
    always_comb begin
        ebus.bus_ctrl_oe = 1'b0;
        ebus.bus_a       = '0;
        ebus.bus_rd_n    = 1'b1;
        ebus.bus_wr_n    = 1'b1;
        ebus.bus_mreq_n  = 1'b1;
        ebus.bus_iorq_n  = 1'b1;
        ebus.bus_d_out   = '0;
        ebus.bus_d_oe    = 1'b0;
        if (r_owner_valid) begin
            ebus.bus_ctrl_oe = 1'b1;
            ebus.bus_a       = ebus.m_a[int'(r_owner)*ADDR_W +: ADDR_W];
            ebus.bus_rd_n    = ebus.m_rd_n[r_owner];
            ebus.bus_wr_n    = ebus.m_wr_n[r_owner];
            ebus.bus_mreq_n  = ebus.m_mreq_n[r_owner];
            ebus.bus_iorq_n  = ebus.m_iorq_n[r_owner];
            ebus.bus_d_out   = ebus.m_wrdata[int'(r_owner)*DATA_W +: DATA_W];
            ebus.bus_d_oe    = ebus.m_wrdata_en[r_owner];
        end
    end

    assign ebus.m_gnt        = r_gnt;
    assign ebus.owner        = r_owner;
    assign ebus.owner_valid  = r_owner_valid;
    assign ebus.hold_timeout = r_hold_timeout;

endmodule

// File: tb/tb_aqp_ebus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_aqp_ebus_arbiter
// Drives two arbiters from the same stimulus: u_fp (fixed priority,
// MAX_HOLD=4) and u_rr (round robin, watchdog off). A timestamp-based
// reference model predicts grants, owner, watchdog flag and bus mux for each
// one; directed steps cover the listed scenarios, followed by random traffic.
// ---------------------------------------------------------------------------
module tb_aqp_ebus_arbiter;
    localparam int N     = 3;
    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int OW    = $clog2(N);
    localparam int TURN  = 2;
    localparam int MH_FP = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clken;
    logic            clr;
    logic [N-1:0]    req;
    logic [N*AW-1:0] a_v;
    logic [N*DW-1:0] wd_v;
    logic [N-1:0]    wden, rd, wr, mreq, iorq;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    // Reference model state, index 0 = u_fp, 1 = u_rr.
    bit mdl_valid [2];
    int mdl_owner [2];
    int mdl_ptr   [2];
    int mdl_free  [2];   // first edge index at which a new grant may be decided
    int mdl_hold  [2];
    bit mdl_to    [2];

    always #5 clk = ~clk;

    aqp_ebus_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) if_fp ();
    aqp_ebus_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) if_rr ();

    assign if_fp.clken = clken;        assign if_rr.clken = clken;
    assign if_fp.m_req = req;          assign if_rr.m_req = req;
    assign if_fp.m_a = a_v;            assign if_rr.m_a = a_v;
    assign if_fp.m_wrdata = wd_v;      assign if_rr.m_wrdata = wd_v;
    assign if_fp.m_wrdata_en = wden;   assign if_rr.m_wrdata_en = wden;
    assign if_fp.m_rd_n = rd;          assign if_rr.m_rd_n = rd;
    assign if_fp.m_wr_n = wr;          assign if_rr.m_wr_n = wr;
    assign if_fp.m_mreq_n = mreq;      assign if_rr.m_mreq_n = mreq;
    assign if_fp.m_iorq_n = iorq;      assign if_rr.m_iorq_n = iorq;
    assign if_fp.hold_timeout_clr = clr;
    assign if_rr.hold_timeout_clr = clr;

    aqp_ebus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(0),
                       .TURNAROUND(TURN), .MAX_HOLD(MH_FP))
        u_fp (.clk(clk), .reset_n(rst_n), .ebus(if_fp));

    aqp_ebus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(1),
                       .TURNAROUND(TURN), .MAX_HOLD(0))
        u_rr (.clk(clk), .reset_n(rst_n), .ebus(if_rr));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Applies the arbitration rules for one clock edge using the current inputs.
    task automatic model_step(input int d);
        int mh;
        bit rr;
        bit set_to;
        bit found;
        mh     = (d == 0) ? MH_FP : 0;
        rr     = (d == 1);
        set_to = 1'b0;
        found  = 1'b0;
        if (!rst_n) begin
            mdl_valid[d] = 1'b0;
            mdl_owner[d] = 0;
            mdl_ptr[d]   = N - 1;
            mdl_free[d]  = cyc + 1;
            mdl_hold[d]  = 0;
            mdl_to[d]    = 1'b0;
        end else begin
            if (mdl_valid[d]) begin
                if (1'(req >> mdl_owner[d]) == 1'b0) begin
                    mdl_valid[d] = 1'b0;
                    mdl_free[d]  = cyc + TURN + 1;
                    mdl_hold[d]  = 0;
                end else if ((req & ~(N'(1) << mdl_owner[d])) != '0) begin
                    if (clken) begin
                        mdl_hold[d]++;
                        if (mh > 0 && mdl_hold[d] == mh) set_to = 1'b1;
                    end
                end else begin
                    mdl_hold[d] = 0;
                end
            end else begin
                mdl_hold[d] = 0;
                if (cyc >= mdl_free[d] && clken && req != '0) begin
                    for (int k = 0; k < N; k++) begin
                        int idx;
                        idx = rr ? (mdl_ptr[d] + 1 + k) % N : k;
                        if (!found && 1'(req >> idx)) begin
                            found        = 1'b1;
                            mdl_owner[d] = idx;
                        end
                    end
                    mdl_ptr[d]   = mdl_owner[d];
                    mdl_valid[d] = 1'b1;
                end
            end
            if (set_to)   mdl_to[d] = 1'b1;
            else if (clr) mdl_to[d] = 1'b0;
        end
    endtask

    task automatic check_dut(input int d, input string nm, input logic [N-1:0] gnt,
                             input logic [OW-1:0] own, input logic ov, input logic to,
                             input logic coe, input logic [AW-1:0] ba, input logic [3:0] strb,
                             input logic [DW-1:0] bd, input logic doe);
        logic [N-1:0]  e_gnt;
        logic [AW-1:0] e_a;
        logic [3:0]    e_s;
        logic [DW-1:0] e_d;
        logic          e_doe;
        int o;
        o     = mdl_owner[d];
        e_gnt = mdl_valid[d] ? (N'(1) << o) : '0;
        if (mdl_valid[d]) begin
            e_a   = a_v[o*AW +: AW];
            e_s   = {1'(rd >> o), 1'(wr >> o), 1'(mreq >> o), 1'(iorq >> o)};
            e_d   = wd_v[o*DW +: DW];
            e_doe = 1'(wden >> o);
        end else begin
            e_a   = '0;
            e_s   = 4'hF;
            e_d   = '0;
            e_doe = 1'b0;
        end
        check($sformatf("%s_gnt@%0d", nm, cyc), gnt, e_gnt);
        check($sformatf("%s_owner@%0d", nm, cyc), own, o);
        check($sformatf("%s_valid@%0d", nm, cyc), ov, mdl_valid[d]);
        check($sformatf("%s_timeout@%0d", nm, cyc), to, mdl_to[d]);
        check($sformatf("%s_ctrl_oe@%0d", nm, cyc), coe, mdl_valid[d]);
        check($sformatf("%s_bus_a@%0d", nm, cyc), ba, e_a);
        check($sformatf("%s_strobes@%0d", nm, cyc), strb, e_s);
        check($sformatf("%s_d_out@%0d", nm, cyc), bd, e_d);
        check($sformatf("%s_d_oe@%0d", nm, cyc), doe, e_doe);
        tests++;
        assert ($onehot0(gnt)) else begin
            failed++;
            $error("FAIL %s_onehot@%0d: observed %b expected one-hot or zero", nm, cyc, gnt);
        end
    endtask

    // One clock: advance the model for the coming edge, then compare after it.
    task automatic step();
        model_step(0);
        model_step(1);
        @(posedge clk);
        cyc++;
        #1;
        check_dut(0, "fp", if_fp.m_gnt, if_fp.owner, if_fp.owner_valid, if_fp.hold_timeout,
                  if_fp.bus_ctrl_oe, if_fp.bus_a,
                  {if_fp.bus_rd_n, if_fp.bus_wr_n, if_fp.bus_mreq_n, if_fp.bus_iorq_n},
                  if_fp.bus_d_out, if_fp.bus_d_oe);
        check_dut(1, "rr", if_rr.m_gnt, if_rr.owner, if_rr.owner_valid, if_rr.hold_timeout,
                  if_rr.bus_ctrl_oe, if_rr.bus_a,
                  {if_rr.bus_rd_n, if_rr.bus_wr_n, if_rr.bus_mreq_n, if_rr.bus_iorq_n},
                  if_rr.bus_d_out, if_rr.bus_d_oe);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int zero_run;
        bit granted;
        int order [4];

        // Reset with every master requesting.
        rst_n = 1'b0; clken = 1'b1; clr = 1'b0; req = '1;
        a_v = (N*AW)'({$urandom(), $urandom()}); wd_v = (N*DW)'($urandom());
        wden = '1; rd = '0; wr = '0; mreq = '0; iorq = '0;
        repeat (3) step();
        check("rst_gnt", if_fp.m_gnt, 0);
        check("rst_ctrl_oe", if_fp.bus_ctrl_oe, 0);
        check("rst_strobes", {if_fp.bus_rd_n, if_fp.bus_wr_n, if_fp.bus_mreq_n, if_fp.bus_iorq_n}, 4'hF);
        check("rst_d_oe", if_fp.bus_d_oe, 0);

        rst_n = 1'b1; clken = 1'b0;
        step();
        check("no_clken_no_gnt", if_fp.m_gnt, 0);
        clken = 1'b1;
        step();
        check("first_gnt_fp", if_fp.m_gnt, 3'b001);
        check("first_gnt_rr", if_rr.m_gnt, 3'b001);

        // Fixed priority, turnaround gap.
        req = '0; clken = 1'b0;
        repeat (5) step();
        req = 3'b110;
        step();
        check("idle_wait_clken", if_fp.m_gnt, 0);
        clken = 1'b1;
        step();
        check("fp_gnt_110", if_fp.m_gnt, 3'b010);
        check("rr_gnt_110", if_rr.m_gnt, 3'b010);
        req = 3'b100;
        zero_run = 0; granted = 1'b0;
        for (int i = 0; i < 12 && !granted; i++) begin
            step();
            if (if_fp.m_gnt === 3'b100) granted = 1'b1;
            else zero_run++;
        end
        check("turn_gap_cycles", zero_run, 1 + TURN);
        check("gnt_after_turn", if_fp.m_gnt, 3'b100);

        // Round robin: three masters, each releasing after 4 clken ticks.
        rst_n = 1'b0; req = '0;
        step();
        rst_n = 1'b1; req = '1; clken = 1'b1;
        for (int g = 0; g < 4; g++) begin
            int waited;
            waited = 0;
            while (if_rr.owner_valid !== 1'b1 && waited < 16) begin
                step();
                waited++;
            end
            check($sformatf("rr_grant_wait%0d", g), if_rr.owner_valid, 1);
            order[g] = int'(if_rr.owner);
            repeat (4) step();
            req = 3'b111 & ~(3'b001 << order[g]);
            step();
            req = '1;
        end
        check("rr_order0", order[0], 0);
        check("rr_order1", order[1], 1);
        check("rr_order2", order[2], 2);
        check("rr_order3", order[3], 0);
        for (int g = 1; g < 4; g++) begin
            tests++;
            assert (order[g] != order[g-1]) else begin
                failed++;
                $error("FAIL rr_repeat%0d: observed owner %0d twice, required a different one", g, order[g]);
            end
        end

        // Bus mux follows owner 1 with zero latency.
        rst_n = 1'b0; req = '0; clken = 1'b0;
        step();
        a_v[AW +: AW] = 16'h3800; wd_v[DW +: DW] = 8'hA5; wden = 3'b010;
        rd = 3'b111; wr = 3'b101; mreq = 3'b101; iorq = 3'b111;
        rst_n = 1'b1; req = 3'b010; clken = 1'b1;
        step();
        check("mux_gnt", if_fp.m_gnt, 3'b010);
        check("mux_bus_a", if_fp.bus_a, 16'h3800);
        check("mux_wr_n", if_fp.bus_wr_n, 0);
        check("mux_d_out", if_fp.bus_d_out, 8'hA5);
        check("mux_d_oe", if_fp.bus_d_oe, 1);
        a_v[AW +: AW] = 16'h3801; a_v[0 +: AW] = 16'hFFFF;
        #1;
        check("mux_zero_latency", if_fp.bus_a, 16'h3801);

        // Reset during an active write.
        rst_n = 1'b0;
        step();
        check("rst_owned_gnt_fp", if_fp.m_gnt, 0);
        check("rst_owned_gnt_rr", if_rr.m_gnt, 0);
        check("rst_owned_ctrl_oe", if_fp.bus_ctrl_oe, 0);
        check("rst_owned_d_oe", if_fp.bus_d_oe, 0);
        check("rst_owned_valid", if_fp.owner_valid, 0);

        // Hold watchdog.
        rst_n = 1'b1; req = 3'b001; clken = 1'b1;
        step();
        req = 3'b101;
        for (int t = 1; t <= 4; t++) begin
            clken = 1'b1; step();
            clken = 1'b0; step();
            check($sformatf("wd_tick%0d", t), if_fp.hold_timeout, (t == 4));
            check($sformatf("wd_gnt%0d", t), if_fp.m_gnt, 3'b001);
        end
        check("wd_disabled_rr", if_rr.hold_timeout, 0);
        clr = 1'b1; step(); clr = 1'b0;
        check("wd_clear", if_fp.hold_timeout, 0);
        req = 3'b100; clken = 1'b1;
        repeat (6) step();
        check("wd_regrant", if_fp.m_gnt, 3'b100);
        req = 3'b101;
        for (int t = 1; t <= 4; t++) begin
            clken = 1'b1; clr = (t == 4); step();
            clken = 1'b0; clr = 1'b0; step();
        end
        check("wd_set_wins", if_fp.hold_timeout, 1);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) req = req ^ (3'b001 << $urandom_range(0, 2));
            clken = ($urandom_range(0, 2) != 0);
            clr   = ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            a_v   = (N*AW)'({$urandom(), $urandom()});
            wd_v  = (N*DW)'($urandom());
            wden  = N'($urandom());
            rd    = N'($urandom());
            wr    = N'($urandom());
            mreq  = N'($urandom());
            iorq  = N'($urandom());
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
